joy_event_fifo: RTL and testbench

//  Parametrised joystick change-event recorder between hps_io and the soc CPU.

---
 rtl/joy_event_fifo.sv | 141 ++++++++++++++
 tb/tb_joy_event_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/joy_event_fifo.sv
// Joystick change-event recorder: round-robin change detection into a show-ahead FIFO.
// Optional timestamping is enabled by defining JOY_EVT_TIMESTAMP_EN.
module joy_event_fifo #(
  parameter int CHANNELS = 6,
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 16,
  localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      ce_ts,
  input  logic [CHANNELS*WIDTH-1:0] joystick,
  input  logic                      evt_rd,
  input  logic                      clr_ovf,
  output logic                      evt_valid,
  output logic [CHAN_W-1:0]         evt_chan,
  output logic [WIDTH-1:0]          evt_data,
  output logic [TS_WIDTH-1:0]       evt_ts,
  output logic [CNT_W-1:0]          evt_count,
  output logic                      overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]  j_q      [CHANNELS];
  logic [WIDTH-1:0]  last_rep [CHANNELS];
  logic [CHAN_W-1:0] rr;
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [CHAN_W-1:0] mem_chan [DEPTH];
  logic [WIDTH-1:0]  mem_data [DEPTH];

  logic [CHANNELS-1:0] pend;
  logic                sel_found;
  logic [CHAN_W-1:0]   sel;
  logic [AW:0]         count;
  logic                full;
  logic                empty;
  logic                pop;
  logic                push;

  // rr + offset stays below 2*CHANNELS, so a single conditional subtract wraps it
  function automatic logic [CHAN_W-1:0] chan_wrap(input int c);
    return (c >= CHANNELS) ? CHAN_W'(c - CHANNELS) : CHAN_W'(c);
  endfunction

  always_comb begin
    pend = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pend[c] = (j_q[c] != last_rep[c]);
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!sel_found && pend[chan_wrap(int'(rr) + i)]) begin
        sel_found = 1'b1;
        sel       = chan_wrap(int'(rr) + i);
      end
    end
  end

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign pop   = evt_rd && !empty;
  assign push  = sel_found && (!full || pop);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        j_q[c]      <= '0;
        last_rep[c] <= '0;
      end
      rr       <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        j_q[c] <= joystick[c*WIDTH +: WIDTH];
      end
      if (push) begin
        last_rep[sel] <= j_q[sel];
        rr            <= (int'(sel) == CHANNELS - 1) ? '0 : sel + 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // a blocked change outranks a same-cycle clear
      if (full && !pop && (|pend)) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem_chan[wr_ptr[AW-1:0]] <= sel;
      mem_data[wr_ptr[AW-1:0]] <= j_q[sel];
    end
  end

  assign evt_valid = !empty;
  assign evt_count = count;
  assign evt_chan  = empty ? '0 : mem_chan[rd_ptr[AW-1:0]];
  assign evt_data  = empty ? '0 : mem_data[rd_ptr[AW-1:0]];

`ifdef JOY_EVT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TS_WIDTH-1:0] mem_ts [DEPTH];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ts_cnt <= '0;
    end else if (ce_ts) begin
      ts_cnt <= ts_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem_ts[wr_ptr[AW-1:0]] <= ts_cnt;
    end
  end

  assign evt_ts = empty ? '0 : mem_ts[rd_ptr[AW-1:0]];
`else
  logic unused_ce_ts;
  assign unused_ce_ts = ce_ts;
  assign evt_ts       = '0;
`endif

endmodule

// File: tb/tb_joy_event_fifo.sv
// Bench for joy_event_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_joy_event_fifo;
  localparam int CHANNELS = 6;
  localparam int WIDTH    = 32;
  localparam int DEPTH    = 16;
  localparam int TS_WIDTH = 4;
  localparam int CHAN_W   = 3;
  localparam int CNT_W    = 5;

  logic                      clk_sys = 1'b0;
  logic                      reset   = 1'b1;
  logic                      ce_ts   = 1'b0;
  logic [CHANNELS*WIDTH-1:0] joystick = '0;
  logic                      evt_rd  = 1'b0;
  logic                      clr_ovf = 1'b0;
  logic                      evt_valid;
  logic [CHAN_W-1:0]         evt_chan;
  logic [WIDTH-1:0]          evt_data;
  logic [TS_WIDTH-1:0]       evt_ts;
  logic [CNT_W-1:0]          evt_count;
  logic                      overflow;

  joy_event_fifo #(
    .CHANNELS(CHANNELS), .WIDTH(WIDTH), .DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_ts(ce_ts), .joystick(joystick),
    .evt_rd(evt_rd), .clr_ovf(clr_ovf), .evt_valid(evt_valid), .evt_chan(evt_chan),
    .evt_data(evt_data), .evt_ts(evt_ts), .evt_count(evt_count), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int                  chan;
    logic [WIDTH-1:0]    data;
    logic [TS_WIDTH-1:0] ts;
  } evt_t;

  evt_t             q[$];
  logic [WIDTH-1:0] m_jq   [CHANNELS];
  logic [WIDTH-1:0] m_last [CHANNELS];
  int               m_rr;
  bit               m_ovf;
  int               m_ts;
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: what one clock edge does, stated as queue operations
  task automatic model_edge();
    bit   pop_now, full_now, found;
    int   pick;
    evt_t e;
    pop_now  = evt_rd && (q.size() != 0);
    full_now = (q.size() == DEPTH);
    found    = 0;
    pick     = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      int c;
      c = (m_rr + i) % CHANNELS;
      if (!found && (m_jq[c] != m_last[c])) begin
        found = 1;
        pick  = c;
      end
    end
    if (pop_now) void'(q.pop_front());
    if (found && (!full_now || pop_now)) begin
      e.chan = pick;
      e.data = m_jq[pick];
`ifdef JOY_EVT_TIMESTAMP_EN
      e.ts   = TS_WIDTH'(m_ts);
`else
      e.ts   = '0;
`endif
      q.push_back(e);
      m_last[pick] = m_jq[pick];
      m_rr = (pick + 1) % CHANNELS;
    end
    if (full_now && !pop_now && found) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
    for (int c = 0; c < CHANNELS; c++) m_jq[c] = joystick[c*WIDTH +: WIDTH];
    if (ce_ts) m_ts = (m_ts + 1) % (1 << TS_WIDTH);
  endtask

  task automatic compare_all();
    check_val("valid", evt_valid, q.size() != 0);
    check_val("count", evt_count, q.size());
    check_val("overflow", overflow, m_ovf);
    if (q.size() != 0) begin
      check_val("head_chan", evt_chan, q[0].chan);
      check_val("head_data", evt_data, q[0].data);
      check_val("head_ts", evt_ts, q[0].ts);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_chan(input int c, input logic [WIDTH-1:0] v);
    joystick[c*WIDTH +: WIDTH] = v;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    evt_rd  = 1'b0;
    clr_ovf = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    q.delete();
    for (int c = 0; c < CHANNELS; c++) begin
      m_jq[c]   = '0;
      m_last[c] = '0;
    end
    m_rr  = 0;
    m_ovf = 0;
    m_ts  = 0;
    check_val("rst_valid", evt_valid, 0);
    check_val("rst_count", evt_count, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_chan", evt_chan, 0);
    check_val("rst_data", evt_data, 0);
    check_val("rst_ts", evt_ts, 0);
    reset = 1'b0;
  endtask

  initial begin
    int rd_pct;
    int exp_chans [5];
    exp_chans = '{0, 3, 5, 0, 3};
    ce_ts = 1'b1;

    // idle joystick produces nothing
    do_reset();
    repeat (6) step();
    check_val("t1_valid", evt_valid, 0);

    // single change, two-edge latency
    set_chan(2, 32'h0000_0010);
    step();
    check_val("t2_e0_valid", evt_valid, 0);
    step();
    check_val("t2_e1_valid", evt_valid, 1);
    check_val("t2_chan", evt_chan, 2);
    check_val("t2_data", evt_data, 32'h10);
    evt_rd = 1'b1;
    step();
    evt_rd = 1'b0;
    check_val("t2_count", evt_count, 0);

    // simultaneous changes, round-robin order
    joystick = '0;
    do_reset();
    set_chan(0, 32'h1); set_chan(3, 32'h3); set_chan(5, 32'h5);
    repeat (4) step();
    set_chan(0, 32'h11); set_chan(3, 32'h33);
    repeat (3) step();
    check_val("t3_count", evt_count, 5);
    for (int k = 0; k < 5; k++) begin
      check_val("t3_order", evt_chan, exp_chans[k]);
      evt_rd = 1'b1;
      step();
      evt_rd = 1'b0;
    end

    // fill to full, then overflow, pop and clear
    joystick = '0;
    do_reset();
    for (int k = 0; k < 17; k++) begin
      set_chan(k % CHANNELS, 32'h100 + k);
      step();
    end
    step();
    check_val("t4_full_count", evt_count, 16);
    check_val("t4_overflow", overflow, 1);
    evt_rd = 1'b1;
    step();
    evt_rd = 1'b0;
    check_val("t4_pop_count", evt_count, 16);
    check_val("t4_tail_data", q[$].data, 32'h110);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check_val("t4_clr", overflow, 0);

    // full with concurrent pop and push
    set_chan(1, 32'hABCD);
    step();
    evt_rd = 1'b1;
    step();
    evt_rd = 1'b0;
    check_val("t5_count", evt_count, 16);
    check_val("t5_overflow", overflow, 0);
    evt_rd = 1'b1;
    repeat (17) step();
    evt_rd = 1'b0;
    check_val("t5_drained", evt_count, 0);

`ifdef JOY_EVT_TIMESTAMP_EN
    joystick = '0;
    do_reset();
    set_chan(0, 32'h1);
    repeat (2) step();
    check_val("t6_ts1", evt_ts, 1);
    evt_rd = 1'b1;
    step();
    evt_rd = 1'b0;
    repeat (17) step();
    set_chan(0, 32'h2);
    repeat (2) step();
    check_val("t6_ts_wrap", evt_ts, 5);
`endif

    // random traffic with alternating drain pressure and a mid-run reset
    for (int blk = 0; blk < 6; blk++) begin
      rd_pct = (blk % 2 == 1) ? 15 : 60;
      for (int n = 0; n < 400; n++) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if ($urandom_range(0, 9) == 0) set_chan(c, WIDTH'($urandom_range(0, 3)));
        end
        evt_rd  = ($urandom_range(0, 99) < rd_pct);
        clr_ovf = ($urandom_range(0, 19) == 0);
        ce_ts   = 1'($urandom_range(0, 1));
        step();
      end
      if (blk == 2) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
